// File: rtl/timer_regs_if.sv
// Single-master register bus between the CPU side and timer_regs.
interface timer_regs_if #(parameter int ADDR_W = 4);
  logic              bus_sel;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (output bus_sel, bus_wr, bus_addr, bus_wdata, input bus_rdata, bus_ack);
  modport slave  (input bus_sel, bus_wr, bus_addr, bus_wdata, output bus_rdata, bus_ack);
endinterface

// File: rtl/timer_regs.sv
// Register front-end for the timing counter: bus decode, trigger pulses, sticky maskable irq.
// Optional TIMER_REGS_LOCK_EN: TERM/MODE writes are discarded (and LOCKERR set) while running.
module timer_regs #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  timer_regs_if.slave      bus,
  output logic             ro_trig_start,
  output logic             ro_trig_halt,
  output logic             ro_mode,
  output logic [CNT_W-1:0] ro_termcount,
  input  logic             rf_status,
  input  logic [CNT_W-1:0] rf_currcount,
  input  logic             rf_int,
  output logic             irq
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_rdata;
  logic        r_ack, r_ien, r_pend, r_lockerr, r_int_d;
  logic [31:0] w_rdata;
  logic [1:0]  w_reg;
  logic        w_hit, w_acc, w_wr, w_lock, w_int_rise;
  logic        w_clr_pend, w_clr_lock, w_lock_set;
  logic        w_unused;

  // Upper address bits only exist for ADDR_W > 4; any set bit there is unmapped.
  generate
    if (ADDR_W > 4) begin : g_hi
      assign w_hit = ~|bus.bus_addr[ADDR_W-1:4];
    end else begin : g_nohi
      assign w_hit = 1'b1;
    end
  endgenerate

`ifdef TIMER_REGS_LOCK_EN
  assign w_lock = rf_status;
`else
  assign w_lock = 1'b0;
`endif

  assign w_unused   = &{1'b0, bus.bus_addr[1:0]};
  assign w_reg      = bus.bus_addr[3:2];
  assign w_acc      = (r_state == S_IDLE) && bus.bus_sel;
  assign w_wr       = w_acc && bus.bus_wr && w_hit;
  assign w_int_rise = rf_int & ~r_int_d;
  assign w_clr_pend = w_wr && (w_reg == 2'd3) && bus.bus_wdata[0];
  assign w_clr_lock = w_wr && (w_reg == 2'd3) && bus.bus_wdata[1];
  // A CTRL write only counts as discarded when it tries to change MODE.
  assign w_lock_set = w_wr && w_lock &&
                      ((w_reg == 2'd1) || ((w_reg == 2'd0) && (bus.bus_wdata[2] != ro_mode)));

  assign bus.bus_rdata = r_rdata;
  assign bus.bus_ack   = r_ack;

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_reg)
        2'd0:    w_rdata = {28'd0, r_ien, ro_mode, 1'b0, rf_status};
        2'd1:    w_rdata = 32'(ro_termcount);
        2'd2:    w_rdata = 32'(rf_currcount);
        default: w_rdata = {30'd0, r_lockerr, r_pend};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rdata       <= '0;
      r_ack         <= 1'b0;
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
      ro_mode       <= 1'b0;
      ro_termcount  <= '0;
      r_ien         <= 1'b0;
      r_pend        <= 1'b0;
      r_lockerr     <= 1'b0;
      r_int_d       <= 1'b0;
      irq           <= 1'b0;
    end else begin
      r_ack         <= 1'b0;
      r_rdata       <= '0;
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
      r_int_d       <= rf_int;
      // Set beats a same-cycle W1C clear.
      r_pend        <= w_int_rise | (r_pend & ~w_clr_pend);
      r_lockerr     <= w_lock_set | (r_lockerr & ~w_clr_lock);
      irq           <= r_pend & r_ien;

      case (r_state)
        S_IDLE: if (bus.bus_sel) begin
          r_state <= S_ACK;
          r_ack   <= 1'b1;
          if (!bus.bus_wr) r_rdata <= w_rdata;
        end
        S_ACK:   r_state <= S_HOLD;
        S_HOLD:  if (!bus.bus_sel) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_wr) begin
        case (w_reg)
          2'd0: begin
            ro_trig_start <= bus.bus_wdata[0] & ~bus.bus_wdata[1];
            ro_trig_halt  <= bus.bus_wdata[1];
            r_ien         <= bus.bus_wdata[3];
            if (!w_lock) ro_mode <= bus.bus_wdata[2];
          end
          2'd1:    if (!w_lock) ro_termcount <= bus.bus_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: vector table plus hand-written irq/handshake/reset sequences.
module tb_timer_regs;
  logic        clk = 1'b0;
  logic        reset;
  logic        ro_trig_start, ro_trig_halt, ro_mode, irq;
  logic [31:0] ro_termcount;
  logic        rf_status, rf_int;
  logic [31:0] rf_currcount;

  timer_regs_if #(.ADDR_W(4)) bi ();

  timer_regs #(.ADDR_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bi.slave),
    .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
    .ro_mode(ro_mode), .ro_termcount(ro_termcount),
    .rf_status(rf_status), .rf_currcount(rf_currcount), .rf_int(rf_int),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_ack = 0, n_start = 0, n_halt = 0;
  logic [31:0] exp_q[$];

`ifdef TIMER_REGS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  always @(negedge clk) begin
    if (!reset) begin
      n_ack   = n_ack   + int'(bi.bus_ack);
      n_start = n_start + int'(ro_trig_start);
      n_halt  = n_halt  + int'(ro_trig_halt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transfer; expected rdata goes into the scoreboard and is popped at ack.
  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp, input bit int_edge,
                      output logic st, output logic hl);
    bit got;
    logic [31:0] e;
    @(negedge clk);
    bi.bus_sel = 1'b1; bi.bus_wr = wr; bi.bus_addr = addr; bi.bus_wdata = wd;
    if (int_edge) rf_int = 1'b1;
    exp_q.push_back(exp);
    got = 1'b0; st = 1'b0; hl = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bi.bus_ack) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk("rdata", bi.bus_rdata, e);
        st = ro_trig_start;
        hl = ro_trig_halt;
      end
    end
    if (!got) begin
      e = exp_q.pop_front();
      chk("ack_timeout", 32'd0, 32'd1);
    end
    bi.bus_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic        st;
    logic [31:0] exp_rd;
    logic [31:0] exp_term;
    logic        exp_mode;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic st, hl;
    int a0, s0, h0;

    tbl[0]  = '{1'b1, 4'h4, 32'd10,         32'd0,         1'b0, 32'd0,         32'd10,         1'b0};
    tbl[1]  = '{1'b1, 4'h0, 32'h4,          32'd0,         1'b0, 32'd0,         32'd10,         1'b1};
    tbl[2]  = '{1'b0, 4'h0, 32'd0,          32'd0,         1'b0, 32'h4,         32'd10,         1'b1};
    tbl[3]  = '{1'b1, 4'h0, 32'h8,          32'd0,         1'b0, 32'd0,         32'd10,         1'b0};
    tbl[4]  = '{1'b0, 4'h0, 32'd0,          32'd0,         1'b1, 32'h9,         32'd10,         1'b0};
    tbl[5]  = '{1'b0, 4'h4, 32'd0,          32'd0,         1'b0, 32'd10,        32'd10,         1'b0};
    tbl[6]  = '{1'b0, 4'h8, 32'd0,          32'd7,         1'b0, 32'd7,         32'd10,         1'b0};
    tbl[7]  = '{1'b1, 4'h8, 32'h55,         32'd7,         1'b0, 32'd0,         32'd10,         1'b0};
    tbl[8]  = '{1'b0, 4'h8, 32'd0,          32'h12345678,  1'b0, 32'h12345678,  32'd10,         1'b0};
    tbl[9]  = '{1'b0, 4'hC, 32'd0,          32'd0,         1'b0, 32'd0,         32'd10,         1'b0};
    tbl[10] = '{1'b1, 4'h4, 32'hFFFFFFFF,   32'd0,         1'b0, 32'd0,         32'hFFFFFFFF,   1'b0};
    tbl[11] = '{1'b0, 4'h5, 32'd0,          32'd0,         1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0};
    tbl[12] = '{1'b1, 4'h7, 32'd10,         32'd0,         1'b0, 32'd0,         32'd10,         1'b0};

    reset = 1'b1;
    bi.bus_sel = 1'b0; bi.bus_wr = 1'b0; bi.bus_addr = '0; bi.bus_wdata = '0;
    rf_status = 1'b0; rf_int = 1'b0; rf_currcount = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(bi.bus_ack), 32'd0);
    chk("rst_rdata", bi.bus_rdata,    32'd0);
    chk("rst_out",   32'({ro_trig_start, ro_trig_halt, ro_mode, irq}), 32'd0);
    chk("rst_term",  ro_termcount,    32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      rf_currcount = tbl[i].cnt;
      rf_status    = tbl[i].st;
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, 1'b0, st, hl);
      chk("vec_term", ro_termcount, tbl[i].exp_term);
      chk("vec_mode", 32'(ro_mode), 32'(tbl[i].exp_mode));
    end
    rf_status = 1'b0;

    // START alone: one pulse, coincident with ack
    s0 = n_start; h0 = n_halt;
    xfer(1'b1, 4'h0, 32'h1, 32'd0, 1'b0, st, hl);
    chk("start_at_ack", 32'(st), 32'd1);
    chk("start_count",  32'(n_start - s0), 32'd1);
    chk("start_nohalt", 32'(n_halt - h0), 32'd0);
    chk("start_mode",   32'(ro_mode), 32'd0);

    // START+HALT: halt wins
    s0 = n_start; h0 = n_halt;
    xfer(1'b1, 4'h0, 32'h3, 32'd0, 1'b0, st, hl);
    chk("both_halt_at_ack", 32'(hl), 32'd1);
    chk("both_halt_count",  32'(n_halt - h0), 32'd1);
    chk("both_no_start",    32'(n_start - s0), 32'd0);

    // bus_sel held 5 cycles: exactly one ack
    a0 = n_ack;
    @(negedge clk);
    bi.bus_sel = 1'b1; bi.bus_wr = 1'b0; bi.bus_addr = 4'h4;
    repeat (5) @(negedge clk);
    bi.bus_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_one_ack", 32'(n_ack - a0), 32'd1);

    // Interrupt: 3-cycle rf_int pulse with IEN
    xfer(1'b1, 4'h0, 32'h8, 32'd0, 1'b0, st, hl);
    rf_int = 1'b1;
    repeat (3) @(negedge clk);
    rf_int = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    xfer(1'b0, 4'hC, 32'd0, 32'd1, 1'b0, st, hl);
    xfer(1'b1, 4'hC, 32'h1, 32'd0, 1'b0, st, hl);
    chk("irq_clr", 32'(irq), 32'd0);
    xfer(1'b0, 4'hC, 32'd0, 32'd0, 1'b0, st, hl);

    // Held level sets PEND once; clearing while still high keeps it clear
    rf_int = 1'b1;
    repeat (2) @(negedge clk);
    xfer(1'b0, 4'hC, 32'd0, 32'd1, 1'b0, st, hl);
    xfer(1'b1, 4'hC, 32'h1, 32'd0, 1'b0, st, hl);
    xfer(1'b0, 4'hC, 32'd0, 32'd0, 1'b0, st, hl);
    chk("level_irq", 32'(irq), 32'd0);
    rf_int = 1'b0;
    @(negedge clk);

    // Set PEND, then W1C on the same edge as a fresh rf_int edge: set wins
    rf_int = 1'b1;
    @(negedge clk);
    rf_int = 1'b0;
    repeat (2) @(negedge clk);
    xfer(1'b1, 4'hC, 32'h1, 32'd0, 1'b1, st, hl);
    rf_int = 1'b0;
    xfer(1'b0, 4'hC, 32'd0, 32'd1, 1'b0, st, hl);
    chk("race_irq", 32'(irq), 32'd1);

    // Lock: TERM write while running
    xfer(1'b1, 4'hC, 32'h3, 32'd0, 1'b0, st, hl);
    rf_status = 1'b1;
    xfer(1'b1, 4'h4, 32'd99, 32'd0, 1'b0, st, hl);
    rf_status = 1'b0;
    chk("lock_term", ro_termcount, LOCK ? 32'd10 : 32'd99);
    xfer(1'b0, 4'hC, 32'd0, LOCK ? 32'd2 : 32'd0, 1'b0, st, hl);

    // Async reset mid-transfer with irq and MODE active
    xfer(1'b1, 4'h0, 32'hC, 32'd0, 1'b0, st, hl);
    rf_int = 1'b1;
    @(negedge clk);
    rf_int = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    bi.bus_sel = 1'b1; bi.bus_wr = 1'b1; bi.bus_addr = 4'h4; bi.bus_wdata = 32'd5;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ack",  32'(bi.bus_ack), 32'd0);
    chk("mid_rst_out",  32'({ro_trig_start, ro_trig_halt, ro_mode, irq}), 32'd0);
    chk("mid_rst_term", ro_termcount, 32'd0);
    bi.bus_sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xfer(1'b0, 4'h4, 32'd0, 32'd0, 1'b0, st, hl);
    xfer(1'b0, 4'hC, 32'd0, 32'd0, 1'b0, st, hl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
